dodge_ring_game: RTL
====================

// Module: dodge_ring_game
// PURPOSE
//  Parametrised successor of the ring-dodge game core: a one-hot player token
//  steps around a ring of NUM_POS positions on each move request.
//  Odd positions are hazard slots whose obstacle blinks at a divided-clock rate.
//  Adds a game FSM with lives, hit recovery, saturating score and a lap pulse.
//  Feeds the LED/7-seg display layer; move/start come from debounced buttons.
// PARAMETERS
//  NUM_POS   8         ring length; even, >=4; hazard slots are the odd indices
//  BLINK_DIV 25000000  Clk cycles per obstacle phase toggle (>=2)
//  SCORE_W   6         score width; saturates at 2**SCORE_W-1
//  LIVES     3         lives per game (1..7)
//  HIT_HOLD  50000000  Clk cycles spent in HIT before resuming (>=1)
// PORTS
//  Clk       in   1        system clock, rising edge
//  Clr       in   1        asynchronous active-high reset
//  start     in   1        level; rising edge starts or restarts a game
//  move      in   1        level; rising edge advances player one position
//  player    out  NUM_POS  one-hot player position
//  obstacle  out  NUM_POS  active obstacle bits (odd indices only)
//  score     out  SCORE_W  safe hazard passes, saturating
//  lives     out  3        remaining lives
//  state     out  2        00 IDLE, 01 PLAY, 10 HIT, 11 OVER
//  hit       out  1        one-cycle pulse on collision
//  lap       out  1        one-cycle pulse on wrap NUM_POS-1 -> 0
// BEHAVIOUR
//  Reset (Clr=1, async): state=IDLE, player=1 (bit0), obstacle=0, score=0,
//   lives=LIVES, hit=0, lap=0, phase=0, divider=0, edge-detect regs=0.
//  Edges: move_rise = move & ~move_q; start_rise likewise; one-cycle latency.
//  Divider: counts only in PLAY; at BLINK_DIV-1 wraps to 0 and toggles phase.
//   Divider and phase are cleared on every entry into PLAY.
//  Obstacle: for odd k, obstacle[k] = phase when in PLAY and player is at k-1
//   or k; all other bits 0; all bits 0 outside PLAY. Registered from current
//   player/phase, so obstacle lags player by one cycle.
//  Collision: coll = in PLAY and |(player & obstacle).
//  FSM:
//   IDLE: start_rise -> PLAY (score=0, lives=LIVES, player=bit0). move ignored.
//   PLAY: coll -> hit=1 for one cycle, lives-=1; lives was 1 -> OVER, else HIT.
//         Else move_rise: rotate player left (bit NUM_POS-1 wraps to bit0,
//         lap=1 same cycle); leaving an odd slot adds 1 to score (saturating).
//         coll has priority: a move in the same cycle is dropped.
//         start_rise ignored in PLAY.
//   HIT:  obstacle=0, moves ignored; after HIT_HOLD cycles -> PLAY with
//         player=bit0, divider/phase cleared.
//   OVER: player/score/lives frozen; start_rise -> PLAY with full reinit.
//  Clr mid-operation: immediate return to reset values, no pulses.
//  All outputs registered; no combinational path from inputs to outputs.
// TESTING (sim params NUM_POS=8, BLINK_DIV=4, LIVES=2, HIT_HOLD=3, SCORE_W=3)
//  Reset, then start pulse -> state=01, player=0x01, lives=2, score=0,
//   obstacle=0 until phase first toggles.
//  8 move pulses, phase held 0 via timing -> player walks 0x02..0x80 -> 0x01,
//   lap=1 exactly once, score=4.
//  Move into slot 1 while phase=1 -> hit pulse, lives=1, state=10 for 3 cycles,
//   then state=01, player=0x01; move on the hit cycle has no effect.
//  Second collision -> lives=0, state=11; moves ignored; start -> state=01,
//   lives=2, score=0.
//  Score saturation: 10 safe hazard passes -> score stops at 7, no wrap.
//  Assert Clr mid-HIT -> state=00, player=0x01, all other outputs 0/LIVES
//   same cycle.

Source files
------------

// File: rtl/dodge_ring_game.sv
// ---------------------------------------------------------------------------
// dodge_ring_game
//   Game core for the ring-dodge toy. A one-hot player token steps around a
//   ring of NUM_POS positions on every rising edge of 'move'. The odd ring
//   positions are hazard slots. When the player is next to or on a hazard
//   slot, that slot's obstacle blinks at a divided-clock rate. A small game
//   FSM tracks lives, a recovery pause after each hit, a saturating score and
//   a one-cycle lap pulse. It feeds the LED/7-seg display layer. 'move' and
//   'start' come from debounced buttons.
//
// Ports
//   Clk       in   1        system clock, rising edge
//   Clr       in   1        asynchronous active-high reset
//   start     in   1        level; rising edge starts or restarts a game
//   move      in   1        level; rising edge advances the player one slot
//   player    out  NUM_POS  one-hot player position
//   obstacle  out  NUM_POS  active obstacle bits (odd indices only)
//   score     out  SCORE_W  safe hazard passes, saturating
//   lives     out  3        remaining lives
//   state     out  2        00 IDLE, 01 PLAY, 10 HIT, 11 OVER
//   hit       out  1        one-cycle pulse on collision
//   lap       out  1        one-cycle pulse on wrap NUM_POS-1 -> 0
// ---------------------------------------------------------------------------
module dodge_ring_game #(
    parameter int NUM_POS   = 8,
    parameter int BLINK_DIV = 25000000,
    parameter int SCORE_W   = 6,
    parameter int LIVES     = 3,
    parameter int HIT_HOLD  = 50000000
) (
    input  logic               Clk,
    input  logic               Clr,
    input  logic               start,
    input  logic               move,
    output logic [NUM_POS-1:0] player,
    output logic [NUM_POS-1:0] obstacle,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic [1:0]         state,
    output logic               hit,
    output logic               lap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam int DIV_W  = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int HOLD_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(BLINK_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HIT_HOLD - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [NUM_POS-1:0] HOME       = NUM_POS'(1);

    // Hazard slots are the odd ring indices.
    function automatic logic [NUM_POS-1:0] odd_mask();
        logic [NUM_POS-1:0] m;
        m = '0;
        for (int k = 1; k < NUM_POS; k += 2) begin
            m[k] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NUM_POS-1:0] ODD_MASK = odd_mask();

    state_t             state_q;
    logic [NUM_POS-1:0] player_q;
    logic [NUM_POS-1:0] obstacle_q;
    logic [SCORE_W-1:0] score_q;
    logic [2:0]         lives_q;
    logic               hit_q;
    logic               lap_q;
    logic               phase_q;
    logic [DIV_W-1:0]   div_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               move_q;
    logic               start_q;

    logic               move_rise;
    logic               start_rise;
    logic               coll;
    logic               leave_odd;
    logic [NUM_POS-1:0] player_rot_d;
    logic [NUM_POS-1:0] obstacle_d;
    logic [SCORE_W-1:0] score_inc_d;

    assign move_rise    = move & ~move_q;
    assign start_rise   = start & ~start_q;
    assign coll         = (state_q == ST_PLAY) && (|(player_q & obstacle_q));
    assign leave_odd    = |(player_q & ODD_MASK);
    assign player_rot_d = {player_q[NUM_POS-2:0], player_q[NUM_POS-1]};
    assign score_inc_d  = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;

    // An obstacle lights only while the player is on its hazard slot or on
    // the even slot just before it, so the player sees a warning one step
    // ahead. It is built from the current player/phase and registered, which
    // makes it trail the player by one cycle.
    always_comb begin
        obstacle_d = '0;
        for (int k = 1; k < NUM_POS; k += 2) begin
            obstacle_d[k] = phase_q & (player_q[k-1] | player_q[k]);
        end
    end

    // Game FSM and all registered outputs. A collision outranks a move in
    // the same cycle, so the move is dropped. Every path into PLAY restarts
    // the blink divider so each round begins with obstacles dark.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q    <= ST_IDLE;
            player_q   <= HOME;
            obstacle_q <= '0;
            score_q    <= '0;
            lives_q    <= LIVES_INIT;
            hit_q      <= 1'b0;
            lap_q      <= 1'b0;
            phase_q    <= 1'b0;
            div_q      <= '0;
            hold_q     <= '0;
            move_q     <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            move_q  <= move;
            start_q <= start;
            hit_q   <= 1'b0;
            lap_q   <= 1'b0;

            case (state_q)
                ST_IDLE, ST_OVER: begin
                    obstacle_q <= '0;
                    if (start_rise) begin
                        state_q  <= ST_PLAY;
                        player_q <= HOME;
                        score_q  <= '0;
                        lives_q  <= LIVES_INIT;
                        div_q    <= '0;
                        phase_q  <= 1'b0;
                    end
                end

                ST_PLAY: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end

                    if (coll) begin
                        hit_q      <= 1'b1;
                        lives_q    <= lives_q - 3'd1;
                        obstacle_q <= '0;
                        hold_q     <= '0;
                        state_q    <= (lives_q == 3'd1) ? ST_OVER : ST_HIT;
                    end else begin
                        obstacle_q <= obstacle_d;
                        if (move_rise) begin
                            player_q <= player_rot_d;
                            lap_q    <= player_q[NUM_POS-1];
                            if (leave_odd) begin
                                score_q <= score_inc_d;
                            end
                        end
                    end
                end

                ST_HIT: begin
                    obstacle_q <= '0;
                    if (hold_q == HOLD_LAST) begin
                        state_q  <= ST_PLAY;
                        player_q <= HOME;
                        div_q    <= '0;
                        phase_q  <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign player   = player_q;
    assign obstacle = obstacle_q;
    assign score    = score_q;
    assign lives    = lives_q;
    assign state    = state_q;
    assign hit      = hit_q;
    assign lap      = lap_q;

endmodule
